// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU MEM stage and a debug/loader port.
// Optional read-return watchdog is compiled in when DMEM_ARB_TIMEOUT_EN is defined.
module dmem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                cpu_req_i,
   input  logic                cpu_we_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [DATA_W-1:0]   cpu_wdata_i,
   input  logic [DATA_W/8-1:0] cpu_be_i,
   output logic                cpu_ack_o,
   output logic [DATA_W-1:0]   cpu_rdata_o,
   output logic                cpu_stall_o,

   input  logic                dbg_req_i,
   input  logic                dbg_we_i,
   input  logic [ADDR_W-1:0]   dbg_addr_i,
   input  logic [DATA_W-1:0]   dbg_wdata_i,
   input  logic [DATA_W/8-1:0] dbg_be_i,
   output logic                dbg_ack_o,
   output logic [DATA_W-1:0]   dbg_rdata_o,

   output logic                mem_valid_o,
   input  logic                mem_ready_i,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,

   output logic                err_o
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

   state_t            state;
   logic              last_dbg;   // 1 = debug port won the most recent grant
   logic              gnt_dbg;

   logic              pick_dbg;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;
   logic              done;
   logic [DATA_W-1:0] done_data;
   logic              timeout_hit;

   // On a tie the requester that did not win last time is chosen.
   assign pick_dbg  = dbg_req_i & (~cpu_req_i | ~last_dbg);
   assign sel_we    = pick_dbg ? dbg_we_i    : cpu_we_i;
   assign sel_addr  = pick_dbg ? dbg_addr_i  : cpu_addr_i;
   assign sel_wdata = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
   assign sel_be    = pick_dbg ? dbg_be_i    : cpu_be_i;

   assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT_R) && !mem_rvalid_i &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      done      = 1'b0;
      done_data = '0;
      if (state == REQ && mem_ready_i && mem_we_o) begin
         done = 1'b1;
      end else if (state == WAIT_R && mem_rvalid_i) begin
         done      = 1'b1;
         done_data = mem_rdata_i;
      end else if (timeout_hit) begin
         done      = 1'b1;
         done_data = DATA_W'(32'hDEAD_BEEF);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_dbg    <= 1'b1;
         gnt_dbg     <= 1'b0;
         cpu_ack_o   <= 1'b0;
         cpu_rdata_o <= '0;
         dbg_ack_o   <= 1'b0;
         dbg_rdata_o <= '0;
         mem_valid_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
      end else begin
         cpu_ack_o <= 1'b0;
         dbg_ack_o <= 1'b0;

         if (done) begin
            if (gnt_dbg) begin
               dbg_ack_o   <= 1'b1;
               dbg_rdata_o <= done_data;
            end else begin
               cpu_ack_o   <= 1'b1;
               cpu_rdata_o <= done_data;
            end
         end

         case (state)
            IDLE: begin
               if (cpu_req_i || dbg_req_i) begin
                  gnt_dbg     <= pick_dbg;
                  last_dbg    <= pick_dbg;
                  mem_valid_o <= 1'b1;
                  mem_we_o    <= sel_we;
                  mem_addr_o  <= sel_addr & ~ADDR_W'(3);
                  mem_wdata_o <= sel_wdata;
                  mem_be_o    <= sel_we ? sel_be : '1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (mem_ready_i) begin
                  mem_valid_o <= 1'b0;
                  state       <= mem_we_o ? RESP : WAIT_R;
               end
            end
            WAIT_R: begin
               if (done) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_TIMEOUT_EN
   // Counter sits at zero outside WAIT_R, so each read-return wait starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err_o    <= 1'b0;
      end else begin
         if (state != WAIT_R) begin
            wait_cnt <= '0;
         end else if (!done) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (timeout_hit) err_o <= 1'b1;
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule
